// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   PC register and instruction-fetch front end. Holds the fetch PC, hands the
//   sequential PC to the jump mux, issues one request at a time to instruction
//   memory and buffers returned words (with their PC) in a small FIFO for
//   decode. A redirect flushes the FIFO and abandons any fetch in flight; the
//   abandoned request's ack is swallowed in the DROP state.
//
//   Optional feature: define FETCH_PERF_CNT_EN to add the performance counter
//   outputs oFetchCnt, oDropCnt and oBubbleCnt.
//
// Ports
//   iClk, iRst     clock (rising edge), asynchronous active-high reset
//   iNewPC         next fetch PC from the jump mux
//   iRedirect      non-sequential target on iNewPC this cycle
//   iStall         decode cannot accept an instruction this cycle
//   oNextPC        fetchPC + PC_INC (combinational, 32-bit wrap)
//   oImemReq       instruction memory request
//   oImemAddr      request address (= fetchPC)
//   iImemAck       memory returns iImemData for the outstanding request
//   iImemData      instruction word, valid with iImemAck
//   oInstrValid    FIFO head valid
//   oInstr         FIFO head instruction, NOP_INSTR when empty
//   oInstrPC       PC of FIFO head, 0 when empty
//   oFetchCnt      (FETCH_PERF_CNT_EN) acks pushed into the FIFO
//   oDropCnt       (FETCH_PERF_CNT_EN) acks discarded
//   oBubbleCnt     (FETCH_PERF_CNT_EN) cycles decode was ready but starved
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] PC_INC    = 32'd1,
   parameter int          BUF_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic [31:0] iNewPC,
   input  logic        iRedirect,
   input  logic        iStall,
   output logic [31:0] oNextPC,
   output logic        oImemReq,
   output logic [31:0] oImemAddr,
   input  logic        iImemAck,
   input  logic [31:0] iImemData,
   output logic        oInstrValid,
   output logic [31:0] oInstr,
   output logic [31:0] oInstrPC
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] oFetchCnt,
   output logic [31:0] oDropCnt,
   output logic [31:0] oBubbleCnt
`endif
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DROP
   } fetchState_t;

   fetchState_t      state, stateNext;
   logic [31:0]      fetchPC;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic [31:0]      instrBuf [BUF_DEPTH];
   logic [31:0]      pcBuf    [BUF_DEPTH];

   logic reqRaised;   // request visible to memory this cycle
   logic ackTaken;    // ack completes the live request
   logic dropAck;     // ack completes an abandoned request
   logic push, pop;

   // Request is raised only while there is room. Because nothing is pushed
   // without an ack, count can only fall while it is up, so it stays up
   // (and oImemAddr stays put) until the ack arrives.
   assign reqRaised = (state == REQ) && (count < DEPTH_C);
   assign ackTaken  = reqRaised && iImemAck;
   assign dropAck   = (state == DROP) && iImemAck;
   assign push      = ackTaken && !iRedirect;
   assign pop       = oInstrValid && !iStall;

   // ---------------------------------------------------------------- FSM
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) state <= IDLE;
      else      state <= stateNext;
   end

   // NOTE: every output of this block gets a default first so no path leaves
   // a variable unassigned and infers a latch.
   always_comb begin
      stateNext = state;
      oImemReq  = 1'b0;
      case (state)
         IDLE: stateNext = REQ;
         REQ: begin
            oImemReq = reqRaised;
            // A redirect with the request outstanding and no ack yet means
            // the memory still owes us a response we must throw away.
            if (iRedirect && reqRaised && !iImemAck) stateNext = DROP;
         end
         DROP: begin
            if (iImemAck) stateNext = REQ;
         end
         default: stateNext = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- PC
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst)                       fetchPC <= RESET_PC;
      else if (iRedirect || ackTaken) fetchPC <= iNewPC;
   end

   assign oNextPC   = fetchPC + PC_INC;
   assign oImemAddr = fetchPC;

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         count <= '0;
         wrPtr <= '0;
         rdPtr <= '0;
      end else if (iRedirect) begin
         // Flush wins over both push and pop.
         count <= '0;
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + PTR_W'(1);
         if (pop)  rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only read once
   // count says it was written, and outputs are masked while empty.
   always_ff @(posedge iClk) begin
      if (push) begin
         instrBuf[wrPtr] <= iImemData;
         pcBuf[wrPtr]    <= fetchPC;
      end
   end

   assign oInstrValid = (count != '0);
   assign oInstr      = oInstrValid ? instrBuf[rdPtr] : NOP_INSTR;
   assign oInstrPC    = oInstrValid ? pcBuf[rdPtr]    : 32'h0000_0000;

`ifdef FETCH_PERF_CNT_EN
   // ---------------------------------------------------------------- perf
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         oFetchCnt  <= '0;
         oDropCnt   <= '0;
         oBubbleCnt <= '0;
      end else begin
         if (push)                    oFetchCnt  <= oFetchCnt + 32'd1;
         if ((ackTaken && iRedirect) || dropAck)
                                      oDropCnt   <= oDropCnt + 32'd1;
         if (!oInstrValid && !iStall) oBubbleCnt <= oBubbleCnt + 32'd1;
      end
   end
`endif

endmodule
